// File: rtl/commit_trace_if.sv
// commit_trace_if: retirement-event inputs, trace record port and status outputs
// of commit_trace_tx, grouped so the producer and consumer share one bundle.
interface commit_trace_if;
  logic        regWrite;
  logic [2:0]  writeReg;
  logic [15:0] wData;
  logic        memRead;
  logic        memWrite;
  logic [15:0] memAddr;
  logic [15:0] memDataIn;
  logic [15:0] memDataOut;
  logic        halt;
  logic        tr_valid;
  logic        tr_ready;
  logic [1:0]  tr_kind;
  logic [2:0]  tr_reg;
  logic [15:0] tr_addr;
  logic [15:0] tr_data;
  logic        trace_full;
  logic        overflow;
  logic        done;
  logic [31:0] inst_count;
  logic [15:0] drop_count;

  modport slave (
    input  regWrite, writeReg, wData, memRead, memWrite, memAddr, memDataIn,
           memDataOut, halt, tr_ready,
    output tr_valid, tr_kind, tr_reg, tr_addr, tr_data, trace_full, overflow,
           done, inst_count, drop_count
  );

  modport master (
    output regWrite, writeReg, wData, memRead, memWrite, memAddr, memDataIn,
           memDataOut, halt, tr_ready,
    input  tr_valid, tr_kind, tr_reg, tr_addr, tr_data, trace_full, overflow,
           done, inst_count, drop_count
  );
endinterface

// File: rtl/commit_trace_tx.sv
// commit_trace_tx: FIFO of retirement events replayed as REG/LOAD/STORE/HALT records
// over a valid/ready port. Optional counters are built when TRACE_COUNTERS_EN is defined.
module commit_trace_tx #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic           clk,
  input logic           rst,
  commit_trace_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [3:0]  flags;  // {halt, store, load, reg}
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] sdata;
    logic [15:0] ldata;
  } entry_t;

  function automatic logic [1:0] first_flag(input logic [3:0] f);
    if (f[0]) return 2'd0;
    if (f[1]) return 2'd1;
    if (f[2]) return 2'd2;
    return 2'd3;
  endfunction

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full_q, overflow_q;
  logic [3:0]       sent_q, sent_d;
  state_t           state_q, state_d;

  entry_t     head, wr_entry;
  logic [3:0] pend, cur_oh;
  logic [1:0] cur;
  logic       last, evt, accept, pop, push, drop;
  logic       tr_valid;
  logic [1:0] tr_kind;
  logic [2:0] tr_reg;
  logic [15:0] tr_addr, tr_data;

  assign wr_entry = '{flags: {bus.halt, bus.memWrite, bus.memRead, bus.regWrite},
                      wreg: bus.writeReg, wdata: bus.wData, addr: bus.memAddr,
                      sdata: bus.memDataIn, ldata: bus.memDataOut};

  // The cursor is the first flag of the head entry not yet emitted.
  assign head   = mem_q[rd_ptr_q];
  assign pend   = head.flags & ~sent_q;
  assign cur    = first_flag(pend);
  assign cur_oh = 4'b0001 << cur;
  assign last   = ((pend & ~cur_oh) == 4'b0000);

  assign evt    = (bus.regWrite | bus.memRead | bus.memWrite | bus.halt) & (state_q != DONE);
  assign accept = (state_q == EMIT) & bus.tr_ready;
  assign pop    = accept & last;
  assign push   = evt & (~full_q | pop);
  assign drop   = evt & full_q & ~pop;
  assign cnt_d  = cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  always_comb begin
    state_d  = state_q;
    sent_d   = sent_q;
    tr_valid = 1'b0;
    tr_kind  = 2'd0;
    tr_reg   = 3'd0;
    tr_addr  = 16'h0000;
    tr_data  = 16'h0000;
    unique case (state_q)
      IDLE: if (cnt_q != '0) state_d = EMIT;
      EMIT: begin
        tr_valid = 1'b1;
        tr_kind  = cur;
        case (cur)
          2'd0: begin tr_reg = head.wreg; tr_data = head.wdata; end
          2'd1: begin tr_addr = head.addr; tr_data = head.ldata; end
          2'd2: begin tr_addr = head.addr; tr_data = head.sdata; end
          default: ;
        endcase
        if (accept) begin
          if (cur == 2'd3) begin
            state_d = DONE;
            sent_d  = 4'b0000;
          end else if (last) begin
            sent_d  = 4'b0000;
            state_d = (cnt_d != '0) ? EMIT : IDLE;
          end else begin
            sent_d = sent_q | cur_oh;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sent_q     <= 4'b0000;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (PTR_W+1)'(DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Entry storage carries data only; the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign bus.tr_valid   = tr_valid;
  assign bus.tr_kind    = tr_kind;
  assign bus.tr_reg     = tr_reg;
  assign bus.tr_addr    = tr_addr;
  assign bus.tr_data    = tr_data;
  assign bus.trace_full = full_q;
  assign bus.overflow   = overflow_q;
  assign bus.done       = (state_q == DONE);

`ifdef TRACE_COUNTERS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] inst_q;
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= 32'd0;
      drop_q <= 16'd0;
    end else begin
      if (evt & (bus.halt | bus.regWrite | bus.memWrite)) inst_q <= sat_inc32(inst_q);
      if (drop) drop_q <= sat_inc16(drop_q);
    end
  end

  assign bus.inst_count = inst_q;
  assign bus.drop_count = drop_q;
`else
  assign bus.inst_count = 32'd0;
  assign bus.drop_count = 16'd0;
`endif
endmodule

// File: tb/tb_commit_trace_tx.sv
// tb_commit_trace_tx: directed table, hand sequences and randomized traffic for
// commit_trace_tx, checked every cycle against a queue-based record model.
module tb_commit_trace_tx;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_trace_if bus();
  commit_trace_tx #(.DEPTH(DEPTH), .PTR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  rg;
    logic [15:0] addr;
    logic [15:0] data;
  } rec_t;

  typedef struct {
    logic [3:0]       f;
    logic [2:0]       wr;
    logic [15:0]      wd, ad, din, dout;
    logic [31:0]      inst;
    int               n;
    logic [3:0][1:0]  k;
    logic [3:0][2:0]  r;
    logic [3:0][15:0] a;
    logic [3:0][15:0] d;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: pending records in order, plus records left per entry.
  rec_t        m_rec[$];
  int          m_ent[$];
  bit          m_valid, m_done, m_ovf, m_full;
  logic [31:0] m_inst;
  logic [15:0] m_drop;

  rec_t got[$];
  int   first_k;
  vec_t tv[7];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef TRACE_COUNTERS_EN
    return v;
`else
    return (v == 32'd0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_rec.delete();
    m_ent.delete();
    m_valid = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_full = 1'b0;
    m_inst = 32'd0; m_drop = 16'd0;
  endtask

  task automatic model_step();
    bit evt, acc, pop, push, drop, halt_acc;
    int sz_pre;
    if (rst) begin
      model_reset();
      return;
    end
    evt  = (bus.regWrite || bus.memRead || bus.memWrite || bus.halt) && !m_done;
    acc  = m_valid && bus.tr_ready;
    pop  = acc && (m_ent[0] == 1);
    push = evt && (!m_full || pop);
    drop = evt && m_full && !pop;
    sz_pre = m_ent.size();
    halt_acc = 1'b0;
    if (acc) begin
      halt_acc = (m_rec[0].kind == 2'd3);
      void'(m_rec.pop_front());
      if (pop) void'(m_ent.pop_front());
      else m_ent[0] = m_ent[0] - 1;
    end
    if (push) begin
      int n = 0;
      if (bus.regWrite) begin m_rec.push_back('{2'd0, bus.writeReg, 16'h0, bus.wData}); n++; end
      if (bus.memRead)  begin m_rec.push_back('{2'd1, 3'd0, bus.memAddr, bus.memDataOut}); n++; end
      if (bus.memWrite) begin m_rec.push_back('{2'd2, 3'd0, bus.memAddr, bus.memDataIn}); n++; end
      if (bus.halt)     begin m_rec.push_back('{2'd3, 3'd0, 16'h0, 16'h0}); n++; end
      m_ent.push_back(n);
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    if (evt && (bus.halt || bus.regWrite || bus.memWrite) && m_inst != 32'hFFFF_FFFF)
      m_inst = m_inst + 32'd1;
    if (halt_acc) begin
      m_done = 1'b1;
      m_valid = 1'b0;
    end else if (!m_done) begin
      if (!m_valid) m_valid = (sz_pre != 0);
      else if (pop) m_valid = (m_ent.size() != 0);
    end
    m_full = (m_ent.size() == DEPTH);
  endtask

  task automatic check_all();
    cmp("tr_valid", 32'(bus.tr_valid), 32'(m_valid));
    if (m_valid && m_rec.size() > 0) begin
      cmp("tr_kind", 32'(bus.tr_kind), 32'(m_rec[0].kind));
      cmp("tr_reg",  32'(bus.tr_reg),  32'(m_rec[0].rg));
      cmp("tr_addr", 32'(bus.tr_addr), 32'(m_rec[0].addr));
      cmp("tr_data", 32'(bus.tr_data), 32'(m_rec[0].data));
    end
    cmp("trace_full", 32'(bus.trace_full), 32'(m_full));
    cmp("overflow", 32'(bus.overflow), 32'(m_ovf));
    cmp("done", 32'(bus.done), 32'(m_done));
    cmp("inst_count", bus.inst_count, cexp(m_inst));
    cmp("drop_count", 32'(bus.drop_count), cexp(32'(m_drop)));
  endtask

  // One clock: model sees the applied inputs, then outputs are checked at negedge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive_ev(input logic [3:0] f, input logic [2:0] wr, input logic [15:0] wd,
                          input logic [15:0] ad, input logic [15:0] din, input logic [15:0] dout);
    bus.regWrite = f[0]; bus.memRead = f[1]; bus.memWrite = f[2]; bus.halt = f[3];
    bus.writeReg = wr; bus.wData = wd; bus.memAddr = ad;
    bus.memDataIn = din; bus.memDataOut = dout;
  endtask

  task automatic clear_ev();
    drive_ev(4'b0000, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic reset_checks(input string pfx);
    cmp({pfx, "_valid"}, 32'(bus.tr_valid), 32'd0);
    cmp({pfx, "_kind"},  32'(bus.tr_kind), 32'd0);
    cmp({pfx, "_reg"},   32'(bus.tr_reg), 32'd0);
    cmp({pfx, "_addr"},  32'(bus.tr_addr), 32'd0);
    cmp({pfx, "_data"},  32'(bus.tr_data), 32'd0);
    cmp({pfx, "_full"},  32'(bus.trace_full), 32'd0);
    cmp({pfx, "_ovf"},   32'(bus.overflow), 32'd0);
    cmp({pfx, "_done"},  32'(bus.done), 32'd0);
    cmp({pfx, "_inst"},  bus.inst_count, 32'd0);
    cmp({pfx, "_drop"},  32'(bus.drop_count), 32'd0);
  endtask

  task automatic do_reset();
    clear_ev();
    bus.tr_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    reset_checks("rst");
  endtask

  // Records shown while tr_ready=1 are accepted, so each valid cycle is one record.
  task automatic collect(input int ncyc);
    got.delete();
    first_k = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (bus.tr_valid) begin
        got.push_back('{bus.tr_kind, bus.tr_reg, bus.tr_addr, bus.tr_data});
        if (first_k < 0) first_k = k;
      end
      cycle();
    end
  endtask

  task automatic set_in(input int i, input logic [3:0] f, input logic [2:0] wr, input logic [15:0] wd,
                        input logic [15:0] ad, input logic [15:0] din, input logic [15:0] dout,
                        input logic [31:0] inst);
    tv[i].f = f; tv[i].wr = wr; tv[i].wd = wd; tv[i].ad = ad;
    tv[i].din = din; tv[i].dout = dout; tv[i].inst = inst; tv[i].n = 0;
  endtask

  task automatic set_out(input int i, input logic [1:0] k, input logic [2:0] r,
                         input logic [15:0] a, input logic [15:0] d);
    tv[i].k[tv[i].n] = k; tv[i].r[tv[i].n] = r;
    tv[i].a[tv[i].n] = a; tv[i].d[tv[i].n] = d;
    tv[i].n = tv[i].n + 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_pct;
    logic [3:0] f;

    // flags: bit0 reg, bit1 load, bit2 store, bit3 halt
    set_in(0, 4'b0001, 3'd3, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 32'd1);
    set_out(0, 2'd0, 3'd3, 16'h0000, 16'h1234);
    set_in(1, 4'b0011, 3'd5, 16'hBEEF, 16'h0040, 16'h0000, 16'hBEEF, 32'd1);
    set_out(1, 2'd0, 3'd5, 16'h0000, 16'hBEEF);
    set_out(1, 2'd1, 3'd0, 16'h0040, 16'hBEEF);
    set_in(2, 4'b0100, 3'd0, 16'h0000, 16'h0010, 16'h00AA, 16'h0000, 32'd1);
    set_out(2, 2'd2, 3'd0, 16'h0010, 16'h00AA);
    set_in(3, 4'b0010, 3'd2, 16'h9999, 16'h0100, 16'h7777, 16'h5555, 32'd0);
    set_out(3, 2'd1, 3'd0, 16'h0100, 16'h5555);
    set_in(4, 4'b0101, 3'd7, 16'h0001, 16'hFFFE, 16'hCAFE, 16'h3C3C, 32'd1);
    set_out(4, 2'd0, 3'd7, 16'h0000, 16'h0001);
    set_out(4, 2'd2, 3'd0, 16'hFFFE, 16'hCAFE);
    set_in(5, 4'b1111, 3'd6, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 32'd1);
    set_out(5, 2'd0, 3'd6, 16'h0000, 16'h1111);
    set_out(5, 2'd1, 3'd0, 16'h2222, 16'h4444);
    set_out(5, 2'd2, 3'd0, 16'h2222, 16'h3333);
    set_out(5, 2'd3, 3'd0, 16'h0000, 16'h0000);
    set_in(6, 4'b1000, 3'd1, 16'h5A5A, 16'h0F0F, 16'h1111, 16'h2222, 32'd1);
    set_out(6, 2'd3, 3'd0, 16'h0000, 16'h0000);

    rst = 1'b1;
    clear_ev();
    bus.tr_ready = 1'b0;
    model_reset();
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      bus.tr_ready = 1'b1;
      drive_ev(tv[i].f, tv[i].wr, tv[i].wd, tv[i].ad, tv[i].din, tv[i].dout);
      cycle();
      clear_ev();
      collect(8);
      cmp($sformatf("v%0d_nrec", i), 32'(got.size()), 32'(tv[i].n));
      cmp($sformatf("v%0d_latency", i), 32'(first_k), 32'd1);
      for (int j = 0; j < tv[i].n && j < got.size(); j++) begin
        cmp($sformatf("v%0d_kind%0d", i, j), 32'(got[j].kind), 32'(tv[i].k[j]));
        cmp($sformatf("v%0d_reg%0d", i, j),  32'(got[j].rg),   32'(tv[i].r[j]));
        cmp($sformatf("v%0d_addr%0d", i, j), 32'(got[j].addr), 32'(tv[i].a[j]));
        cmp($sformatf("v%0d_data%0d", i, j), 32'(got[j].data), 32'(tv[i].d[j]));
      end
      cmp($sformatf("v%0d_inst", i), bus.inst_count, cexp(tv[i].inst));
      cmp($sformatf("v%0d_done", i), 32'(bus.done), 32'(tv[i].f[3]));
    end

    // Backpressure: eight stores fill the FIFO, a ninth is dropped.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_ev(4'b0100, 3'd0, 16'h0, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 16'h0);
      cycle();
    end
    cmp("bp_full", 32'(bus.trace_full), 32'd1);
    cmp("bp_hold_addr", 32'(bus.tr_addr), 32'h0100);
    drive_ev(4'b0100, 3'd0, 16'h0, 16'h0200, 16'hDEAD, 16'h0);
    cycle();
    clear_ev();
    cmp("bp_overflow", 32'(bus.overflow), 32'd1);
    cmp("bp_drop", 32'(bus.drop_count), cexp(32'd1));
    cmp("bp_inst", bus.inst_count, cexp(32'd9));
    cmp("bp_hold_data", 32'(bus.tr_data), 32'hA000);
    bus.tr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmp($sformatf("bp_valid%0d", i), 32'(bus.tr_valid), 32'd1);
      cmp($sformatf("bp_kind%0d", i), 32'(bus.tr_kind), 32'd2);
      cmp($sformatf("bp_addr%0d", i), 32'(bus.tr_addr), 32'h0100 + i);
      cmp($sformatf("bp_data%0d", i), 32'(bus.tr_data), 32'hA000 + i);
      cycle();
    end
    cmp("bp_idle", 32'(bus.tr_valid), 32'd0);

    // Full FIFO: a new event lands on the cycle the head entry's last record pops.
    do_reset();
    drive_ev(4'b0011, 3'd1, 16'hAAAA, 16'h0040, 16'h0, 16'hBBBB);
    cycle();
    for (int i = 1; i < 8; i++) begin
      drive_ev(4'b0001, 3'(i), 16'h1000 + 16'(i), 16'h0, 16'h0, 16'h0);
      cycle();
    end
    clear_ev();
    cmp("fp_full", 32'(bus.trace_full), 32'd1);
    bus.tr_ready = 1'b1;
    cycle();
    cmp("fp_load_kind", 32'(bus.tr_kind), 32'd1);
    drive_ev(4'b0001, 3'd4, 16'h7777, 16'h0, 16'h0, 16'h0);
    cycle();
    clear_ev();
    cmp("fp_overflow", 32'(bus.overflow), 32'd0);
    cmp("fp_full_after", 32'(bus.trace_full), 32'd1);
    collect(12);
    cmp("fp_nrec", 32'(got.size()), 32'd8);
    if (got.size() == 8) cmp("fp_last_data", 32'(got[7].data), 32'h7777);

    // Halt: STORE then HALT, later events ignored.
    do_reset();
    bus.tr_ready = 1'b1;
    drive_ev(4'b0100, 3'd0, 16'h0, 16'h0010, 16'h00AA, 16'h0);
    cycle();
    drive_ev(4'b1000, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    cycle();
    clear_ev();
    collect(6);
    cmp("halt_nrec", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      cmp("halt_k0", 32'(got[0].kind), 32'd2);
      cmp("halt_a0", 32'(got[0].addr), 32'h0010);
      cmp("halt_d0", 32'(got[0].data), 32'h00AA);
      cmp("halt_k1", 32'(got[1].kind), 32'd3);
    end
    cmp("halt_done", 32'(bus.done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_ev(4'b0001, 3'd2, 16'h4321, 16'h0, 16'h0, 16'h0);
      cycle();
    end
    clear_ev();
    cycle();
    cmp("halt_quiet", 32'(bus.tr_valid), 32'd0);
    cmp("halt_inst", bus.inst_count, cexp(32'd2));
    cmp("halt_nodrop", 32'(bus.overflow), 32'd0);

    // Reset mid-stream with three entries pending.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive_ev(4'b0001, 3'(i), 16'h2000 + 16'(i), 16'h0, 16'h0, 16'h0);
      cycle();
    end
    clear_ev();
    cmp("mr_valid_before", 32'(bus.tr_valid), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    reset_checks("mr");
    bus.tr_ready = 1'b1;
    drive_ev(4'b0001, 3'd2, 16'h0F0F, 16'h0, 16'h0, 16'h0);
    cycle();
    clear_ev();
    collect(4);
    cmp("mr_nrec", 32'(got.size()), 32'd1);
    if (got.size() == 1) begin
      cmp("mr_reg", 32'(got[0].rg), 32'd2);
      cmp("mr_data", 32'(got[0].data), 32'h0F0F);
    end

    // Randomized traffic with varying consumer throughput.
    rdy_pct = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) rdy_pct = (c % 600 == 0) ? 100 : ((c % 600 == 200) ? 15 : 60);
      rst = ($urandom_range(0, 299) == 0) || (m_done && $urandom_range(0, 15) == 0);
      f[0] = ($urandom_range(0, 2) == 0);
      f[1] = ($urandom_range(0, 3) == 0);
      f[2] = ($urandom_range(0, 3) == 0);
      f[3] = ($urandom_range(0, 149) == 0);
      drive_ev(f, 3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      bus.tr_ready = ($urandom_range(0, 99) < rdy_pct);
      cycle();
    end
    rst = 1'b0;
    clear_ev();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
